// File: rtl/exe_seq_pkg.sv
// Shared types and constants for the execution-unit operation sequencer.
package exe_seq_pkg;

    // Sequencer control states: one operation in flight at a time.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

    // Width of the execution-unit status word.
    localparam int STATUS_W = 4;

    // Default operand and opcode widths of the execution unit.
    localparam int DEF_ARG_W  = 4;
    localparam int DEF_OPER_W = 2;

    // Command layout at the default widths.
    // Modules with other widths rebuild the same field order locally.
    typedef struct packed {
        logic [DEF_OPER_W-1:0] oper;
        logic [DEF_ARG_W-1:0]  argA;
        logic [DEF_ARG_W-1:0]  argB;
    } cmd_t;

    // Number of bits in a packed command for the given widths.
    function automatic int cmd_bits(input int arg_w, input int oper_w);
        return oper_w + 2 * arg_w;
    endfunction

endpackage

// File: rtl/seq_cmd_fifo.sv
// Small synchronous command FIFO.
// The head entry is read straight out of the storage registers, so it is
// stable for the whole cycle. A pop is honoured only when the FIFO held
// data before the edge, so there is no write-to-read bypass.
module seq_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // The extra pointer bit separates "full" from "empty" when the indices match.
    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];

    // Compute the next storage contents and pointer positions.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = i_wdata;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage registers; contents are don't-care while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/exe_op_sequencer.sv
// Wrapper stage around a registered execution unit.
// Commands are queued, issued one at a time with operands held stable,
// and the registered result is captured and offered to a consumer.
// A saturating counter tracks results whose status is non-zero.
module exe_op_sequencer
    import exe_seq_pkg::*;
#(
    parameter int m     = 4,
    parameter int n     = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [n-1:0]        i_cmd_oper,
    input  logic [m-1:0]        i_cmd_argA,
    input  logic [m-1:0]        i_cmd_argB,
    output logic [n-1:0]        o_oper,
    output logic [m-1:0]        o_argA,
    output logic [m-1:0]        o_argB,
    input  logic [m-1:0]        i_exe_result,
    input  logic [STATUS_W-1:0] i_exe_status,
    output logic                o_res_valid,
    input  logic                i_res_ready,
    output logic [m-1:0]        o_res_data,
    output logic [STATUS_W-1:0] o_res_status,
    output logic [n-1:0]        o_res_oper,
    output logic [CNT_W-1:0]    o_err_cnt,
    output logic                o_busy
);

    // Same field order as exe_seq_pkg::cmd_t, sized by this instance.
    typedef struct packed {
        logic [n-1:0] oper;
        logic [m-1:0] argA;
        logic [m-1:0] argB;
    } seq_cmd_t;

    localparam int CMD_W = cmd_bits(m, n);

    seq_state_t          state_q, state_d;
    seq_cmd_t            fifo_wdata;
    seq_cmd_t            fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_push;
    logic                fifo_pop;

    logic [n-1:0]        oper_q, oper_d;
    logic [m-1:0]        arg_a_q, arg_a_d;
    logic [m-1:0]        arg_b_q, arg_b_d;
    logic                res_valid_q, res_valid_d;
    logic [m-1:0]        res_data_q, res_data_d;
    logic [STATUS_W-1:0] res_status_q, res_status_d;
    logic [n-1:0]        res_oper_q, res_oper_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    assign o_cmd_ready = !fifo_full && !i_rst;
    assign fifo_push   = i_cmd_valid && o_cmd_ready;
    assign fifo_wdata  = '{oper: i_cmd_oper, argA: i_cmd_argA, argB: i_cmd_argB};

    seq_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_pop   (fifo_pop),
        .i_wdata (fifo_wdata),
        .o_rdata (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // State register: reset abandons any operation in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: issue, let the unit register operands, sample, then hold for the consumer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!fifo_empty) state_d = DRIVE;
            DRIVE:   state_d = SAMPLE;
            SAMPLE:  state_d = HOLD;
            HOLD:    if (i_res_ready) state_d = fifo_empty ? IDLE : DRIVE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: pop and load operands, capture results, count errors.
    always_comb begin
        fifo_pop     = 1'b0;
        oper_d       = oper_q;
        arg_a_d      = arg_a_q;
        arg_b_d      = arg_b_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        res_oper_d   = res_oper_q;
        err_cnt_d    = err_cnt_q;

        unique case (state_q)
            IDLE: fifo_pop = !fifo_empty;
            SAMPLE: begin
                res_valid_d  = 1'b1;
                res_data_d   = i_exe_result;
                res_status_d = i_exe_status;
                res_oper_d   = oper_q;
                if ((|i_exe_status) && (err_cnt_q != {CNT_W{1'b1}})) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (i_res_ready) begin
                    res_valid_d = 1'b0;
                    fifo_pop    = !fifo_empty;
                end
            end
            default: ;
        endcase

        if (fifo_pop) begin
            oper_d  = fifo_head.oper;
            arg_a_d = fifo_head.argA;
            arg_b_d = fifo_head.argB;
        end
    end

    // Output registers; reset clears everything the consumer or unit can see.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            oper_q       <= '0;
            arg_a_q      <= '0;
            arg_b_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_status_q <= '0;
            res_oper_q   <= '0;
            err_cnt_q    <= '0;
        end else begin
            oper_q       <= oper_d;
            arg_a_q      <= arg_a_d;
            arg_b_q      <= arg_b_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
            res_oper_q   <= res_oper_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign o_oper       = oper_q;
    assign o_argA       = arg_a_q;
    assign o_argB       = arg_b_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_data   = res_data_q;
    assign o_res_status = res_status_q;
    assign o_res_oper   = res_oper_q;
    assign o_err_cnt    = err_cnt_q;
    assign o_busy       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_exe_op_sequencer.sv
// Self-checking bench for exe_op_sequencer with a registered XOR execution-unit stub.
// A second instance with a 2-bit error counter sees identical stimulus.
module tb_exe_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmdValid;
   logic [1:0] cmdOper;
   logic [3:0] cmdArgA;
   logic [3:0] cmdArgB;
   logic       resReady;

   logic       cmdReady, cmdReadyS;
   logic [1:0] oper, operS;
   logic [3:0] argA, argAS, argB, argBS;
   logic [3:0] exeResult, exeResultS;
   logic [3:0] exeStatus, exeStatusS;
   logic       resValid, resValidS;
   logic [3:0] resData, resDataS;
   logic [3:0] resStatus, resStatusS;
   logic [1:0] resOper, resOperS;
   logic [7:0] errCnt;
   logic [1:0] errCntS;
   logic       busy, busyS;
   logic       exeRsn;

   typedef struct {
      logic [1:0] oper;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] res;
      logic [3:0] st;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   errExp8 = 0;
   int   errExp2 = 0;

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] watchdog");
   end

   assign exeRsn = ~rst;

   exe_op_sequencer #(.m(4), .n(2), .DEPTH(4), .CNT_W(8)) dut (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady),
      .i_cmd_oper(cmdOper), .i_cmd_argA(cmdArgA), .i_cmd_argB(cmdArgB),
      .o_oper(oper), .o_argA(argA), .o_argB(argB),
      .i_exe_result(exeResult), .i_exe_status(exeStatus),
      .o_res_valid(resValid), .i_res_ready(resReady), .o_res_data(resData),
      .o_res_status(resStatus), .o_res_oper(resOper), .o_err_cnt(errCnt), .o_busy(busy)
   );

   exe_op_sequencer #(.m(4), .n(2), .DEPTH(4), .CNT_W(2)) dutSat (
      .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReadyS),
      .i_cmd_oper(cmdOper), .i_cmd_argA(cmdArgA), .i_cmd_argB(cmdArgB),
      .o_oper(operS), .o_argA(argAS), .o_argB(argBS),
      .i_exe_result(exeResultS), .i_exe_status(exeStatusS),
      .o_res_valid(resValidS), .i_res_ready(resReady), .o_res_data(resDataS),
      .o_res_status(resStatusS), .o_res_oper(resOperS), .o_err_cnt(errCntS), .o_busy(busyS)
   );

   // Registered execution-unit stubs: result = A ^ B, status flags a zero result.
   always_ff @(posedge clk) begin
      if (!exeRsn) begin
         exeResult  <= '0;
         exeStatus  <= '0;
         exeResultS <= '0;
         exeStatusS <= '0;
      end else begin
         exeResult  <= argA ^ argB;
         exeStatus  <= {3'b000, (argA ^ argB) == 4'h0};
         exeResultS <= argAS ^ argBS;
         exeStatusS <= {3'b000, (argAS ^ argBS) == 4'h0};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic exp_t mkExp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      e.oper = op;
      e.a    = a;
      e.b    = b;
      e.res  = a ^ b;
      e.st   = {3'b000, (a ^ b) == 4'h0};
      return e;
   endfunction

   // Offer one command, wait (bounded) for acceptance, record the expected result.
   task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      bit done = 1'b0;
      cmdValid = 1'b1;
      cmdOper  = op;
      cmdArgA  = a;
      cmdArgB  = b;
      for (int k = 0; k < 50 && !done; k++) begin
         if (cmdReady) done = 1'b1;
         tick();
      end
      cmdValid = 1'b0;
      checkOutput("cmd_accepted", 32'(done), 32'd1);
      if (done) sb.push_back(mkExp(op, a, b));
   endtask

   // Wait (bounded) for a result, compare it with the scoreboard head, then let it be consumed.
   task automatic waitResult(input string tag, output int seenCyc);
      bit   seen = 1'b0;
      exp_t e;
      seenCyc = -1;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (resValid) seen = 1'b1;
         else tick();
      end
      checkOutput({tag, "_valid"}, 32'(seen), 32'd1);
      if (seen) begin
         seenCyc = cyc;
         if (sb.size() == 0) begin
            checkOutput({tag, "_unexpected"}, 32'd1, 32'(sb.size()));
         end else begin
            e = sb.pop_front();
            if (e.st != 4'h0) begin
               errExp8 = (errExp8 == 255) ? 255 : errExp8 + 1;
               errExp2 = (errExp2 == 3) ? 3 : errExp2 + 1;
            end
            checkOutput({tag, "_data"}, 32'(resData), 32'(e.res));
            checkOutput({tag, "_status"}, 32'(resStatus), 32'(e.st));
            checkOutput({tag, "_oper"}, 32'(resOper), 32'(e.oper));
            checkOutput({tag, "_errcnt"}, 32'(errCnt), 32'(errExp8));
            checkOutput({tag, "_errcnt_sat"}, 32'(errCntS), 32'(errExp2));
         end
      end
      tick();
   endtask

   initial begin
      int   accepted;
      int   c0, c1, c2, dummy;
      bit   readyNow;
      exp_t head;

      rst      = 1'b1;
      cmdValid = 1'b0;
      cmdOper  = '0;
      cmdArgA  = '0;
      cmdArgB  = '0;
      resReady = 1'b0;
      tick();
      tick();

      // Reset state.
      checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd0);
      checkOutput("rst_res_valid", 32'(resValid), 32'd0);
      checkOutput("rst_oper", 32'(oper), 32'd0);
      checkOutput("rst_err_cnt", 32'(errCnt), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("rel_cmd_ready", 32'(cmdReady), 32'd1);

      // Single op with exact latency.
      resReady = 1'b1;
      applyStimulus(2'b01, 4'h3, 4'h5);
      checkOutput("lat_e0_valid", 32'(resValid), 32'd0);
      tick();
      checkOutput("lat_e1_valid", 32'(resValid), 32'd0);
      checkOutput("lat_e1_oper", 32'(oper), 32'd1);
      checkOutput("lat_e1_argA", 32'(argA), 32'h3);
      checkOutput("lat_e1_argB", 32'(argB), 32'h5);
      checkOutput("lat_e1_busy", 32'(busy), 32'd1);
      tick();
      checkOutput("lat_e2_valid", 32'(resValid), 32'd0);
      tick();
      checkOutput("lat_e3_valid", 32'(resValid), 32'd1);
      waitResult("single", dummy);
      checkOutput("single_after_valid", 32'(resValid), 32'd0);
      checkOutput("single_after_busy", 32'(busy), 32'd0);

      // Fill: eight cycles of offered commands with the consumer stalled.
      resReady = 1'b0;
      accepted = 0;
      cmdValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cmdOper  = 2'(i);
         cmdArgA  = 4'(i);
         cmdArgB  = 4'hA;
         readyNow = cmdReady;
         tick();
         if (readyNow) begin
            accepted++;
            sb.push_back(mkExp(2'(i), 4'(i), 4'hA));
         end
      end
      cmdValid = 1'b0;
      checkOutput("fill_accepted", 32'(accepted), 32'd5);
      checkOutput("fill_cmd_ready", 32'(cmdReady), 32'd0);

      // Backpressure: result and issued operands stay put.
      head = sb[0];
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_valid", 32'(resValid), 32'd1);
         checkOutput("bp_data", 32'(resData), 32'(head.res));
         checkOutput("bp_res_oper", 32'(resOper), 32'(head.oper));
         checkOutput("bp_oper", 32'(oper), 32'(head.oper));
         checkOutput("bp_argA", 32'(argA), 32'(head.a));
         checkOutput("bp_argB", 32'(argB), 32'(head.b));
         tick();
      end

      // One ready pulse frees a FIFO slot.
      resReady = 1'b1;
      waitResult("bp_release", dummy);
      resReady = 1'b0;
      checkOutput("pulse_cmd_ready", 32'(cmdReady), 32'd1);

      // Drain the rest in order.
      resReady = 1'b1;
      for (int i = 0; i < 4; i++) waitResult("drain", dummy);
      checkOutput("drain_sb_empty", 32'(sb.size()), 32'd0);
      checkOutput("drain_busy", 32'(busy), 32'd0);

      // Back-to-back results every three cycles.
      applyStimulus(2'b10, 4'h1, 4'h2);
      applyStimulus(2'b11, 4'h4, 4'h4);
      applyStimulus(2'b00, 4'h7, 4'h1);
      waitResult("b2b0", c0);
      waitResult("b2b1", c1);
      waitResult("b2b2", c2);
      checkOutput("b2b_gap01", 32'(c1 - c0), 32'd3);
      checkOutput("b2b_gap12", 32'(c2 - c1), 32'd3);

      // Reset while sampling with two commands still queued.
      applyStimulus(2'b01, 4'h2, 4'h2);
      applyStimulus(2'b10, 4'h5, 4'h6);
      applyStimulus(2'b11, 4'h9, 4'h3);
      rst = 1'b1;
      tick();
      sb.delete();
      errExp8 = 0;
      errExp2 = 0;
      checkOutput("mid_rst_valid", 32'(resValid), 32'd0);
      checkOutput("mid_rst_oper", 32'(oper), 32'd0);
      checkOutput("mid_rst_argA", 32'(argA), 32'd0);
      checkOutput("mid_rst_argB", 32'(argB), 32'd0);
      checkOutput("mid_rst_data", 32'(resData), 32'd0);
      checkOutput("mid_rst_status", 32'(resStatus), 32'd0);
      checkOutput("mid_rst_res_oper", 32'(resOper), 32'd0);
      checkOutput("mid_rst_err_cnt", 32'(errCnt), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_cmd_ready", 32'(cmdReady), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_cmd_ready", 32'(cmdReady), 32'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("post_rst_quiet", 32'(resValid), 32'd0);
      end
      checkOutput("post_rst_busy", 32'(busy), 32'd0);

      // Saturation: five zero-result operations.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(2'(i), 4'(i + 3), 4'(i + 3));
         waitResult("sat", dummy);
      end
      checkOutput("sat_final_cnt", 32'(errCnt), 32'd5);
      checkOutput("sat_final_cnt_sat", 32'(errCntS), 32'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
